// File: rtl/vram_port_arbiter.sv
// Single-port VRAM arbiter: display fetch has priority, CPU writes are buffered, starvation guard forces CPU slots.
// Defining VRAM_ARB_STATS_EN adds the disp_stall_cnt / cpu_force_cnt / wbuf_full_seen statistics ports.
module vram_port_arbiter #(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 8,
  parameter int WBUF_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              cpu_wr_valid,
  input  logic [ADDR_W-1:0] cpu_wr_addr,
  input  logic [DATA_W-1:0] cpu_wr_data,
  output logic              cpu_wr_ready,
  input  logic              cpu_rd_req,
  input  logic [ADDR_W-1:0] cpu_rd_addr,
  output logic              cpu_rd_valid,
  output logic [DATA_W-1:0] cpu_rd_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [15:0]       disp_stall_cnt,
  output logic [15:0]       cpu_force_cnt,
  output logic [0:0]        wbuf_full_seen
`endif
);

  localparam int PTR_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DISP,
    ST_WR,
    ST_RD
  } state_t;

  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_DISP,
    TAG_CPU
  } tag_t;

  logic [ADDR_W-1:0] wbuf_addr_mem [WBUF_DEPTH];
  logic [DATA_W-1:0] wbuf_data_mem [WBUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              rd_outstanding_reg;
  logic [STV_W-1:0]  starve_cnt_reg;
  state_t            state_reg;
  state_t            state_next;
  tag_t              tag_reg;

  logic push;
  logic pop;
  logic wbuf_nonempty;
  logic rd_eligible;
  logic cpu_pending;
  logic forced;
  logic cpu_grant;

  assign cpu_wr_ready  = (count_reg < CNT_W'(WBUF_DEPTH));
  assign push          = cpu_wr_valid & cpu_wr_ready & ~rst;
  assign wbuf_nonempty = (count_reg != '0);
  // A write being pushed this cycle must land in VRAM before any read overtakes it.
  assign rd_eligible   = cpu_rd_req & ~rd_outstanding_reg & ~wbuf_nonempty & ~push;
  assign cpu_pending   = wbuf_nonempty | rd_eligible;
  assign forced        = (starve_cnt_reg == STV_W'(STARVE_LIMIT)) & cpu_pending & ~rst;

  always_comb begin
    state_next = ST_IDLE;
    if (rst) begin
      state_next = ST_IDLE;
    end else if (forced) begin
      state_next = wbuf_nonempty ? ST_WR : ST_RD;
    end else if (disp_req) begin
      state_next = ST_DISP;
    end else if (wbuf_nonempty) begin
      state_next = ST_WR;
    end else if (rd_eligible) begin
      state_next = ST_RD;
    end
  end

  assign disp_gnt  = (state_next == ST_DISP);
  assign pop       = (state_next == ST_WR);
  assign cpu_grant = (state_next == ST_WR) || (state_next == ST_RD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      wbuf_addr_mem[wr_ptr_reg] <= cpu_wr_addr;
      wbuf_data_mem[wr_ptr_reg] <= cpu_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_reg <= '0;
    end else if (cpu_grant) begin
      starve_cnt_reg <= '0;
    end else if (disp_gnt && cpu_pending && (starve_cnt_reg < STV_W'(STARVE_LIMIT))) begin
      starve_cnt_reg <= starve_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_outstanding_reg <= 1'b0;
    end else if (state_next == ST_RD) begin
      rd_outstanding_reg <= 1'b1;
    end else if (cpu_rd_valid) begin
      rd_outstanding_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      mem_re <= (state_next == ST_DISP) || (state_next == ST_RD);
      mem_we <= (state_next == ST_WR);
      case (state_next)
        ST_DISP: mem_addr <= disp_addr;
        ST_RD:   mem_addr <= cpu_rd_addr;
        ST_WR: begin
          mem_addr  <= wbuf_addr_mem[rd_ptr_reg];
          mem_wdata <= wbuf_data_mem[rd_ptr_reg];
        end
        default: mem_addr <= mem_addr;
      endcase
    end
  end

  // state_reg is the first tag stage (aligned with mem_re); tag_reg aligns with mem_rdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_reg <= TAG_NONE;
    end else begin
      case (state_reg)
        ST_DISP: tag_reg <= TAG_DISP;
        ST_RD:   tag_reg <= TAG_CPU;
        default: tag_reg <= TAG_NONE;
      endcase
    end
  end

  assign disp_valid   = (tag_reg == TAG_DISP) & ~rst;
  assign cpu_rd_valid = (tag_reg == TAG_CPU) & ~rst;
  assign disp_data    = mem_rdata;
  assign cpu_rd_data  = mem_rdata;

`ifdef VRAM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_stall_cnt <= '0;
      cpu_force_cnt  <= '0;
      wbuf_full_seen <= '0;
    end else begin
      if (disp_req && !disp_gnt && (disp_stall_cnt != 16'hFFFF)) begin
        disp_stall_cnt <= disp_stall_cnt + 16'd1;
      end
      if (forced && (cpu_force_cnt != 16'hFFFF)) begin
        cpu_force_cnt <= cpu_force_cnt + 16'd1;
      end
      if (count_reg == CNT_W'(WBUF_DEPTH)) begin
        wbuf_full_seen <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Self-checking bench for vram_port_arbiter: directed scenarios plus randomized traffic against a VRAM/ordering model.
`timescale 1ns/1ps
module tb_vram_port_arbiter;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_gnt;
  logic              disp_valid;
  logic [DATA_W-1:0] disp_data;
  logic              cpu_wr_valid;
  logic [ADDR_W-1:0] cpu_wr_addr;
  logic [DATA_W-1:0] cpu_wr_data;
  logic              cpu_wr_ready;
  logic              cpu_rd_req;
  logic [ADDR_W-1:0] cpu_rd_addr;
  logic              cpu_rd_valid;
  logic [DATA_W-1:0] cpu_rd_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
`ifdef VRAM_ARB_STATS_EN
  logic [15:0]       disp_stall_cnt;
  logic [15:0]       cpu_force_cnt;
  logic [0:0]        wbuf_full_seen;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vram_port_arbiter #(
    .ADDR_W(14), .DATA_W(8), .WBUF_DEPTH(4), .STARVE_LIMIT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_valid(disp_valid), .disp_data(disp_data),
    .cpu_wr_valid(cpu_wr_valid), .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
    .cpu_wr_ready(cpu_wr_ready),
    .cpu_rd_req(cpu_rd_req), .cpu_rd_addr(cpu_rd_addr),
    .cpu_rd_valid(cpu_rd_valid), .cpu_rd_data(cpu_rd_data),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef VRAM_ARB_STATS_EN
    , .disp_stall_cnt(disp_stall_cnt), .cpu_force_cnt(cpu_force_cnt),
    .wbuf_full_seen(wbuf_full_seen)
`endif
  );

  // Unwritten VRAM locations hold an address-derived pattern.
  function automatic logic [7:0] init_val(input logic [13:0] a);
    return a[7:0] ^ {a[13:8], 2'b01};
  endfunction

  // VRAM model: one-cycle registered read; every write is logged in issue order.
  logic [7:0]  vram [int];
  logic [21:0] wr_log [$];
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= vram.exists(int'(mem_addr)) ? vram[int'(mem_addr)] : init_val(mem_addr);
    if (mem_we) begin
      vram[int'(mem_addr)] = mem_wdata;
      wr_log.push_back({mem_addr, mem_wdata});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    disp_req = 0; disp_addr = '0;
    cpu_wr_valid = 0; cpu_wr_addr = '0; cpu_wr_data = '0;
    cpu_rd_req = 0; cpu_rd_addr = '0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    repeat (3) step();
    rst = 0;
    #1;
    checks++; if (disp_gnt !== 1'b0) begin errors++; $display("FAIL reset_disp_gnt: got %b expected 0", disp_gnt); end
    checks++; if (disp_valid !== 1'b0 || cpu_rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valids: got %b%b expected 00", disp_valid, cpu_rd_valid); end
    checks++; if (mem_re !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got re=%b we=%b expected 0 0", mem_re, mem_we); end
    checks++; if (mem_addr !== 14'h0 || mem_wdata !== 8'h0) begin errors++; $display("FAIL reset_mem_bus: got addr=%h wdata=%h expected 0 0", mem_addr, mem_wdata); end
    checks++; if (cpu_wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b expected 1", cpu_wr_ready); end
`ifdef VRAM_ARB_STATS_EN
    checks++; if (disp_stall_cnt !== 16'h0 || cpu_force_cnt !== 16'h0 || wbuf_full_seen !== 1'b0) begin
      errors++; $display("FAIL reset_stats: got %h %h %b expected 0 0 0", disp_stall_cnt, cpu_force_cnt, wbuf_full_seen);
    end
`endif
  endtask

  task automatic test_idle_write();
    step();
    cpu_wr_valid = 1; cpu_wr_addr = 14'h0100; cpu_wr_data = 8'hA5;
    #1;
    checks++; if (cpu_wr_ready !== 1'b1) begin errors++; $display("FAIL idle_wr_accept: got ready=%b expected 1", cpu_wr_ready); end
    step();
    cpu_wr_valid = 0;
    #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL idle_wr_early: got mem_we=%b expected 0", mem_we); end
    step();
    checks++; if (mem_we !== 1'b1 || mem_addr !== 14'h0100 || mem_wdata !== 8'hA5) begin
      errors++; $display("FAIL idle_wr_issue: got we=%b addr=%h data=%h expected 1 0100 a5", mem_we, mem_addr, mem_wdata);
    end
    checks++; if (cpu_wr_ready !== 1'b1) begin errors++; $display("FAIL idle_wr_ready: got %b expected 1", cpu_wr_ready); end
    step();
  endtask

  task automatic test_disp_read();
    step();
    disp_req = 1; disp_addr = 14'h3800;
    #1;
    checks++; if (disp_gnt !== 1'b1) begin errors++; $display("FAIL disp_gnt: got %b expected 1", disp_gnt); end
    step();
    disp_req = 0;
    #1;
    checks++; if (mem_re !== 1'b1 || mem_addr !== 14'h3800) begin errors++; $display("FAIL disp_mem_re: got re=%b addr=%h expected 1 3800", mem_re, mem_addr); end
    step();
    checks++; if (disp_valid !== 1'b1 || disp_data !== init_val(14'h3800)) begin
      errors++; $display("FAIL disp_data: got valid=%b data=%h expected 1 %h", disp_valid, disp_data, init_val(14'h3800));
    end
    step();
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL disp_valid_pulse: got %b expected 0", disp_valid); end
  endtask

  task automatic test_starvation();
    int denied = 0;
    bit found = 0;
`ifdef VRAM_ARB_STATS_EN
    logic [15:0] force_before;
    force_before = cpu_force_cnt;
`endif
    step();
    disp_req = 1; disp_addr = 14'h3800;
    cpu_wr_valid = 1; cpu_wr_addr = 14'h0101; cpu_wr_data = 8'h5A;
    #1;
    step();
    cpu_wr_valid = 0;
    #1;
    for (int i = 0; i < 30; i++) begin
      if (disp_gnt === 1'b1) denied++;
      else begin found = 1; break; end
      step();
    end
    checks++; if (!found || denied != 8) begin errors++; $display("FAIL starve_denied: got found=%0d denied=%0d expected 1 8", found, denied); end
    step();
    checks++; if (mem_we !== 1'b1 || mem_addr !== 14'h0101 || mem_wdata !== 8'h5A) begin
      errors++; $display("FAIL starve_write: got we=%b addr=%h data=%h expected 1 0101 5a", mem_we, mem_addr, mem_wdata);
    end
    checks++; if (disp_gnt !== 1'b1) begin errors++; $display("FAIL starve_disp_resume: got %b expected 1", disp_gnt); end
`ifdef VRAM_ARB_STATS_EN
    checks++; if (cpu_force_cnt !== force_before + 16'd1) begin errors++; $display("FAIL starve_force_cnt: got %0d expected %0d", cpu_force_cnt, force_before + 16'd1); end
`endif
    disp_req = 0;
    repeat (3) step();
  endtask

  task automatic test_buffer_full();
    logic [21:0] exp_q [$];
    int base = wr_log.size();
    bit accepted = 0;
    bit pop_seen;
    step();
    disp_req = 1; disp_addr = 14'h3801;
    for (int i = 0; i < 4; i++) begin
      cpu_wr_valid = 1; cpu_wr_addr = 14'h0200 + 14'(i); cpu_wr_data = 8'($urandom);
      #1;
      checks++; if (cpu_wr_ready !== 1'b1) begin errors++; $display("FAIL full_push%0d: got ready=%b expected 1", i, cpu_wr_ready); end
      exp_q.push_back({cpu_wr_addr, cpu_wr_data});
      step();
    end
    cpu_wr_valid = 1; cpu_wr_addr = 14'h0204; cpu_wr_data = 8'($urandom);
    #1;
    checks++; if (cpu_wr_ready !== 1'b0) begin errors++; $display("FAIL full_ready_low: got %b expected 0", cpu_wr_ready); end
    for (int k = 0; k < 40; k++) begin
      if (cpu_wr_ready === 1'b1) begin accepted = 1; break; end
      step();
    end
    pop_seen = (mem_we === 1'b1) || (wr_log.size() > base);
    checks++; if (!accepted || !pop_seen) begin errors++; $display("FAIL full_fifth_accept: got accepted=%0d pop_seen=%0d expected 1 1", accepted, pop_seen); end
    exp_q.push_back({cpu_wr_addr, cpu_wr_data});
`ifdef VRAM_ARB_STATS_EN
    checks++; if (wbuf_full_seen !== 1'b1) begin errors++; $display("FAIL full_seen: got %b expected 1", wbuf_full_seen); end
`endif
    step();
    cpu_wr_valid = 0; disp_req = 0;
    for (int k = 0; k < 40 && wr_log.size() < base + 5; k++) step();
    checks++; if (wr_log.size() != base + 5) begin errors++; $display("FAIL full_drain: got %0d writes expected 5", wr_log.size() - base); end
    for (int i = 0; i < 5 && base + i < wr_log.size(); i++) begin
      checks++; if (wr_log[base + i] !== exp_q[i]) begin errors++; $display("FAIL full_order%0d: got %h expected %h", i, wr_log[base + i], exp_q[i]); end
    end
    repeat (2) step();
  endtask

  task automatic test_raw();
    bit got = 0;
    step();
    cpu_wr_valid = 1; cpu_wr_addr = 14'h0010; cpu_wr_data = 8'h3C;
    cpu_rd_req = 1; cpu_rd_addr = 14'h0010;
    #1;
    for (int k = 0; k < 20; k++) begin
      step();
      cpu_wr_valid = 0;
      #1;
      if (cpu_rd_valid === 1'b1) begin got = 1; break; end
    end
    checks++; if (!got || cpu_rd_data !== 8'h3C) begin errors++; $display("FAIL raw_read: got valid=%0d data=%h expected 1 3c", got, cpu_rd_data); end
    step();
    cpu_rd_req = 0;
    repeat (3) step();
  endtask

  task automatic test_reset_mid_read();
    bit bad = 0;
    step();
    cpu_rd_req = 1; cpu_rd_addr = 14'h0020;
    #1;
    step();
    cpu_wr_valid = 1; cpu_wr_addr = 14'h0030; cpu_wr_data = 8'h77;
    #1;
    checks++; if (mem_re !== 1'b1) begin errors++; $display("FAIL rstrd_mem_re: got %b expected 1", mem_re); end
    step();
    cpu_wr_valid = 0; rst = 1;
    #1;
    checks++; if (cpu_rd_valid !== 1'b0) begin errors++; $display("FAIL rstrd_valid_in_rst: got %b expected 0", cpu_rd_valid); end
    step();
    rst = 0; cpu_rd_req = 0;
    #1;
    checks++; if (mem_re !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 14'h0 || mem_wdata !== 8'h0) begin
      errors++; $display("FAIL rstrd_mem: got re=%b we=%b addr=%h wdata=%h expected 0 0 0 0", mem_re, mem_we, mem_addr, mem_wdata);
    end
    checks++; if (cpu_wr_ready !== 1'b1 || cpu_rd_valid !== 1'b0 || disp_valid !== 1'b0) begin
      errors++; $display("FAIL rstrd_outputs: got ready=%b rdv=%b dv=%b expected 1 0 0", cpu_wr_ready, cpu_rd_valid, disp_valid);
    end
    for (int k = 0; k < 5; k++) begin
      step();
      if (cpu_rd_valid !== 1'b0 || mem_we !== 1'b0) bad = 1;
    end
    checks++; if (bad) begin errors++; $display("FAIL rstrd_quiet: got stray rd_valid or mem_we expected none"); end
  endtask

  task automatic test_random();
    logic [7:0]  shadow [64];
    logic [7:0]  disp_exp [$];
    logic [21:0] wexp [$];
    int base = wr_log.size();
    bit disp_active = 0, rd_active = 0, new_rd, wv;
    logic [13:0] disp_a = '0, rd_a = '0;
    logic [7:0]  rd_exp = '0;
    int rd_wait = 0;
    bit conflict = 0;
    for (int i = 0; i < 64; i++) shadow[i] = init_val(14'h0400 + 14'(i));
    for (int cyc = 0; cyc < 800; cyc++) begin
      step();
      new_rd = 0;
      if (cyc < 760) begin
        if (!disp_active && $urandom_range(0, 9) < 7) begin disp_active = 1; disp_a = 14'h3800 + 14'($urandom_range(0, 2047)); end
        wv = !rd_active && ($urandom_range(0, 3) == 0);
        if (!rd_active && $urandom_range(0, 7) == 0) begin rd_active = 1; rd_a = 14'h0400 + 14'($urandom_range(0, 63)); rd_wait = 0; new_rd = 1; end
      end else wv = 0;
      disp_req = disp_active; disp_addr = disp_a;
      cpu_wr_valid = wv; cpu_wr_addr = 14'h0400 + 14'($urandom_range(0, 63)); cpu_wr_data = 8'($urandom);
      cpu_rd_req = rd_active; cpu_rd_addr = rd_a;
      #1;
      if (wv && cpu_wr_ready === 1'b1) begin
        shadow[cpu_wr_addr[5:0]] = cpu_wr_data;
        wexp.push_back({cpu_wr_addr, cpu_wr_data});
      end
      if (new_rd) rd_exp = shadow[rd_a[5:0]];
      if (disp_active && disp_gnt === 1'b1) begin disp_exp.push_back(init_val(disp_a)); disp_active = 0; end
      if (disp_valid === 1'b1) begin
        checks++;
        if (disp_exp.size() == 0) begin errors++; $display("FAIL rnd_disp_spurious: got data=%h expected no valid", disp_data); end
        else begin
          if (disp_data !== disp_exp[0]) begin errors++; $display("FAIL rnd_disp_data: got %h expected %h", disp_data, disp_exp[0]); end
          void'(disp_exp.pop_front());
        end
      end
      if (cpu_rd_valid === 1'b1) begin
        checks++;
        if (!rd_active || cpu_rd_data !== rd_exp) begin errors++; $display("FAIL rnd_cpu_rd: got active=%0d data=%h expected 1 %h addr %h", rd_active, cpu_rd_data, rd_exp, rd_a); end
        rd_active = 0;
      end else if (rd_active) begin
        rd_wait++;
        if (rd_wait > 64) begin checks++; errors++; $display("FAIL rnd_cpu_rd_timeout: got no valid after %0d cycles expected valid", rd_wait); rd_active = 0; end
      end
      if (mem_re === 1'b1 && mem_we === 1'b1) conflict = 1;
    end
    idle_inputs();
    for (int k = 0; k < 30; k++) begin
      step();
      if (disp_valid === 1'b1 && disp_exp.size() > 0) begin
        checks++; if (disp_data !== disp_exp[0]) begin errors++; $display("FAIL rnd_disp_tail: got %h expected %h", disp_data, disp_exp[0]); end
        void'(disp_exp.pop_front());
      end
    end
    checks++; if (conflict) begin errors++; $display("FAIL rnd_one_op: got re and we together expected exclusive"); end
    checks++; if (disp_exp.size() != 0 || rd_active) begin errors++; $display("FAIL rnd_pending: got %0d disp left, rd_active=%0d expected 0 0", disp_exp.size(), rd_active); end
    checks++; if (wr_log.size() - base != wexp.size()) begin errors++; $display("FAIL rnd_wr_count: got %0d expected %0d", wr_log.size() - base, wexp.size()); end
    for (int i = 0; i < wexp.size() && base + i < wr_log.size(); i++) begin
      if (wr_log[base + i] !== wexp[i]) begin checks++; errors++; $display("FAIL rnd_wr_order%0d: got %h expected %h", i, wr_log[base + i], wexp[i]); break; end
    end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_idle_write();
    test_disp_read();
    test_starvation();
    test_buffer_full();
    test_raw();
    test_reset_mid_read();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_port_arbiter.md
Name: vram_port_arbiter

Overview:
- Shares the single VRAM access port between two requesters:
  - the display fetch path, which feeds per-pixel pattern/name-table reads to the VGA output;
  - the CPU data-port path, which carries Z80 reads and writes through the VDP data port.
- Display fetch has priority, but a starvation guard guarantees CPU forward progress.
- CPU writes are buffered so the Z80 side does not stall while the display is busy.

Parameters:
- ADDR_W, 14, VRAM address width (16 KB).
- DATA_W, 8, VRAM data width.
- WBUF_DEPTH, 4, CPU write-buffer entries (power of 2, ≥2).
- STARVE_LIMIT, 8, consecutive CPU-denied cycles before CPU is forced through.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- disp_req  in  1  display read request; held with disp_addr until disp_gnt.
- disp_addr  in  ADDR_W  display read address.
- disp_gnt  out  1  combinational; request accepted this cycle.
- disp_valid  out  1  one-cycle pulse; disp_data valid.
- disp_data  out  DATA_W  display read data.
- cpu_wr_valid  in  1  CPU write offer.
- cpu_wr_addr  in  ADDR_W  CPU write address.
- cpu_wr_data  in  DATA_W  CPU write data.
- cpu_wr_ready  out  1  write buffer has space.
- cpu_rd_req  in  1  CPU read request; held until cpu_rd_valid.
- cpu_rd_addr  in  ADDR_W  CPU read address.
- cpu_rd_valid  out  1  one-cycle pulse; cpu_rd_data valid.
- cpu_rd_data  out  DATA_W  CPU read data.
- mem_addr  out  ADDR_W  registered VRAM address.
- mem_re  out  1  registered VRAM read enable.
- mem_we  out  1  registered VRAM write enable.
- mem_wdata  out  DATA_W  registered VRAM write data.
- mem_rdata  in  DATA_W  VRAM read data, valid the cycle after mem_re.

Behaviour:
- At most one VRAM operation per cycle. The grant decision in cycle T is combinational. mem_* are registered and asserted in T+1. Read data is returned in T+2.
- Reset values:
  - all valid/gnt/re/we outputs = 0; mem_addr = 0; mem_wdata = 0;
  - cpu_wr_ready = 1; buffer empty; starvation counter = 0;
  - FSM = IDLE; read-tag pipeline cleared.
- Write buffer:
  - FIFO; a push occurs when cpu_wr_valid & cpu_wr_ready.
  - cpu_wr_ready = (count < WBUF_DEPTH), taken from the registered count. It does not rise in the same cycle as a pop.
- Grant priority, evaluated each cycle:
  1. CPU forced, when starve_cnt == STARVE_LIMIT and CPU work is pending. Forced service is a buffer pop if the buffer is non-empty, else the read.
  2. Display, when disp_req.
  3. Buffer pop, when the buffer is non-empty.
  4. CPU read, when cpu_rd_req, the buffer is empty and no CPU read is outstanding.
- Read-after-write ordering: a CPU read is never issued while the buffer is non-empty. A write pushed in the same cycle as cpu_rd_req drains before the read issues.
- FSM states:
  - IDLE
  - DISP: display read issued.
  - WR: buffer pop issued.
  - RD: CPU read issued.
  - Any state moves to any other state per the priority order each cycle.
  - RD additionally sets rd_outstanding, which is cleared on cpu_rd_valid. Only one CPU read may be outstanding.
- Read return:
  - A 2-stage tag pipeline (DISP/CPU/none) follows each mem_re.
  - At T+2 the matching valid pulses for 1 cycle; data = mem_rdata.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) each cycle CPU work is pending but display is granted.
  - Clears on any CPU grant.
- Display back-to-back: disp_req held continuously receives a grant every cycle, except for forced CPU slots.
- Reset mid-operation: in-flight reads are discarded (no valid pulse), buffered writes are dropped, and mem_we = 0 the cycle after rst is sampled.

Optional Feature:
- Macro: VRAM_ARB_STATS_EN.
- When defined, adds these output ports, each cleared by rst:
  - disp_stall_cnt [15:0]: cycles with disp_req=1 & disp_gnt=0; saturates.
  - cpu_force_cnt [15:0]: forced CPU grants; saturates.
  - wbuf_full_seen [0:0]: sticky; set when count == WBUF_DEPTH.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Idle CPU write: write addr 14'h0100, data 8'hA5 → mem_we=1, mem_addr=14'h0100, mem_wdata=8'hA5 exactly 2 cycles after the push; cpu_wr_ready stays 1.
- Display read only: disp_req with addr 14'h3800 → disp_gnt same cycle; mem_re next cycle; disp_valid with VRAM[14'h3800] two cycles after gnt.
- Starvation: disp_req held high, plus 1 buffered write → write reaches mem_we after exactly 8 denied cycles (STARVE_LIMIT=8); disp_gnt=0 that one cycle; cpu_force_cnt=1 if STATS enabled.
- Buffer full: disp_req held, 5 consecutive writes → cpu_wr_ready=0 after the 4th push; 5th accepted only after a pop; VRAM order preserved.
- RAW ordering: write 8'h3C to 14'h0010 and read 14'h0010 in the same cycle → cpu_rd_valid returns 8'h3C.
- Reset mid-read: assert rst one cycle after a CPU read's mem_re → no cpu_rd_valid; all outputs return to reset values; cpu_wr_ready=1.
